ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 57 +++++
 rtl/ps2_line_filter.sv | 71 +++++++
 rtl/ps2_host_tx.sv | 247 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and the PS/2 line filter.
//   - tx_state_e      : host-to-device frame sequencer state encoding
//   - timing units    : INHIBIT length (us), global timeout (ms), per-bit
//                       timeout (ms), turned into clock cycles by the helper
//                       functions below from the system clock in kHz
//   - edge indices    : falling-edge numbers inside a host-to-device frame
//   - odd_parity()    : PS/2 parity bit for a data byte
// ----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } tx_state_e;

  // Clock-low inhibit before a request-to-send, in microseconds
  localparam int INHIBIT_US     = 32'd100;
  // Whole-frame watchdog limit, in milliseconds
  localparam int TIMEOUT_MS     = 32'd15;
  // Limit between two device clock edges, in milliseconds
  localparam int BIT_TIMEOUT_MS = 32'd2;
  localparam int US_PER_MS      = 32'd1000;
  // The INHIBIT sequencer needs a "last cycle" and a "one before last" cycle
  localparam int MIN_INHIBIT    = 32'd2;

  // Falling-edge indices within a host-to-device frame
  localparam logic [3:0] EDGE_START  = 4'd0;
  localparam logic [3:0] EDGE_PARITY = 4'd9;
  localparam logic [3:0] EDGE_STOP   = 4'd10;
  localparam logic [3:0] EDGE_ACK    = 4'd11;

  function automatic int inhibit_cycles(input int clk_khz);
    int n;
    n = (clk_khz * INHIBIT_US) / US_PER_MS;
    return (n < MIN_INHIBIT) ? MIN_INHIBIT : n;
  endfunction

  function automatic int timeout_cycles(input int clk_khz);
    return clk_khz * TIMEOUT_MS;
  endfunction

  function automatic int bit_timeout_cycles(input int clk_khz);
    return clk_khz * BIT_TIMEOUT_MS;
  endfunction

  // PS/2 uses odd parity: the parity bit makes the count of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ----------------------------------------------------------------------------
// ps2_line_filter
// Conditions one raw PS/2 line (clock or data) for use in the clk domain:
// two-flop synchroniser, then a glitch filter that accepts a new level only
// after FILT_LEN consecutive synchronised samples agree on it, then a
// falling-edge detector on the filtered level.
//
// Parameters:
//   FILT_LEN : consecutive equal samples needed to accept a level change
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset (filtered level returns to 1)
//   line_in  : raw, asynchronous line level
//   filt     : filtered line level
//   fall     : one-cycle pulse in the first cycle filt reads 0 after a 1
// ----------------------------------------------------------------------------
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic filt,
  output logic fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          filt_r;
  logic          fall_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchroniser; resets high like a released open-drain line
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= line_in;
      sync2_r <= sync1_r;
    end
  end

  // Glitch filter: count consecutive samples that disagree with the held level
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_r <= 1'b1;
      fall_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else begin
      fall_r <= 1'b0;
      if (sync2_r == filt_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        // The level flips now; a 1->0 flip is reported in the same cycle
        filt_r <= sync2_r;
        fall_r <= filt_r;
        cnt_r  <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end
  end

  assign filt = filt_r;
  assign fall = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. On an accepted tx_start the block inhibits
// the bus (clock low for 100 us), issues a request-to-send (data low, clock
// released), shifts out 8 data bits LSB first plus odd parity on the device's
// falling clock edges, releases data for the stop bit, samples the device ACK
// on edge 11 and waits for the bus to go idle before reporting the result.
//
// Build option:
//   PS2_HOST_TX_TIMEOUT_EN : adds a watchdog (15 ms per frame, 2 ms between
//                            device clock edges) that aborts the frame and
//                            pulses tmo_err. Without it tmo_err is tied low
//                            and the block waits for the device forever.
//
// Parameters:
//   CLK_KHZ    : system clock frequency in kHz, all timing derives from it
//   FILT_LEN   : glitch filter length used on both PS/2 lines
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   tx_data    : byte to send, captured in the tx_start cycle
//   tx_start   : one-cycle send request, honoured only while idle
//   clkps2_in  : raw PS/2 clock line level
//   dataps2_in : raw PS/2 data line level
//   clkps2_oe  : 1 pulls the PS/2 clock line low
//   dataps2_oe : 1 pulls the PS/2 data line low
//   busy       : high from the cycle after accept until back in IDLE
//   done       : one-cycle pulse, frame acknowledged by the device
//   ack_err    : one-cycle pulse, device did not acknowledge
//   tmo_err    : one-cycle pulse, watchdog expired (timeout build only)
// ----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int CLK_KHZ  = 12000,
  parameter int FILT_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       clkps2_in,
  input  logic       dataps2_in,
  output logic       clkps2_oe,
  output logic       dataps2_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       tmo_err
);

  import ps2_pkg::*;

  localparam int INH_CYC = inhibit_cycles(CLK_KHZ);
  localparam int INH_W   = $clog2(INH_CYC);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INH_CYC - 2);

  tx_state_e        state_r;
  logic [INH_W-1:0] inh_tmr_r;
  logic [3:0]       edge_cnt_r;
  // {parity, data}; bit 0 is the next bit to put on the line
  logic [8:0]       frame_r;
  logic             nack_r;
  logic             clk_oe_r;
  logic             data_oe_r;
  logic             busy_r;
  logic             done_r;
  logic             ack_err_r;

  logic             clk_filt_s;
  logic             clk_fall_s;
  logic             data_filt_s;
  logic             data_fall_unused_s;

  ps2_line_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_clk_filt (
    .clk     (clk),
    .rst     (rst),
    .line_in (clkps2_in),
    .filt    (clk_filt_s),
    .fall    (clk_fall_s)
  );

  ps2_line_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_data_filt (
    .clk     (clk),
    .rst     (rst),
    .line_in (dataps2_in),
    .filt    (data_filt_s),
    .fall    (data_fall_unused_s)
  );

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TOT_CYC = timeout_cycles(CLK_KHZ);
  localparam int BIT_CYC = bit_timeout_cycles(CLK_KHZ);
  localparam int TOT_W   = $clog2(TOT_CYC);
  localparam int BIT_W   = $clog2(BIT_CYC);
  localparam logic [TOT_W-1:0] TOT_LAST = TOT_W'(TOT_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_CYC - 1);

  logic [TOT_W-1:0] tot_tmr_r;
  logic [BIT_W-1:0] bit_tmr_r;
  logic             wd_run_s;
  logic             tmo_hit_s;
  logic             tmo_err_r;

  // Watchdog is armed only while waiting on the device
  always_comb begin
    wd_run_s = 1'b0;
    case (state_r)
      ST_REQ, ST_SHIFT, ST_ACK, ST_WAIT_IDLE: wd_run_s = 1'b1;
      default:                                wd_run_s = 1'b0;
    endcase
    tmo_hit_s = wd_run_s && ((tot_tmr_r == TOT_LAST) || (bit_tmr_r == BIT_LAST));
  end

  // Frame and per-bit timers; both start from zero when INHIBIT ends
  always_ff @(posedge clk) begin
    if (rst) begin
      tot_tmr_r <= {TOT_W{1'b0}};
      bit_tmr_r <= {BIT_W{1'b0}};
    end else if (!wd_run_s) begin
      tot_tmr_r <= {TOT_W{1'b0}};
      bit_tmr_r <= {BIT_W{1'b0}};
    end else begin
      tot_tmr_r <= tot_tmr_r + TOT_W'(1'b1);
      if (clk_fall_s) begin
        bit_tmr_r <= {BIT_W{1'b0}};
      end else begin
        bit_tmr_r <= bit_tmr_r + BIT_W'(1'b1);
      end
    end
  end

  assign tmo_err = tmo_err_r;
`else
  assign tmo_err = 1'b0;
`endif

  // Frame sequencer: drives both lines, counts device edges, reports results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      inh_tmr_r  <= {INH_W{1'b0}};
      edge_cnt_r <= EDGE_START;
      frame_r    <= 9'd0;
      nack_r     <= 1'b0;
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ack_err_r  <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      tmo_err_r  <= 1'b0;
`endif
    end else begin
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      tmo_err_r <= 1'b0;
      // Watchdog abort overrides whatever the sequencer would do this cycle
      if (tmo_hit_s) begin
        state_r   <= ST_IDLE;
        clk_oe_r  <= 1'b0;
        data_oe_r <= 1'b0;
        busy_r    <= 1'b0;
        tmo_err_r <= 1'b1;
      end else
`endif
      begin
        case (state_r)
          ST_IDLE: begin
            if (tx_start) begin
              state_r    <= ST_INHIBIT;
              inh_tmr_r  <= {INH_W{1'b0}};
              edge_cnt_r <= EDGE_START;
              frame_r    <= {odd_parity(tx_data), tx_data};
              nack_r     <= 1'b0;
              clk_oe_r   <= 1'b1;
              busy_r     <= 1'b1;
            end
          end

          ST_INHIBIT: begin
            inh_tmr_r <= inh_tmr_r + INH_W'(1'b1);
            // Start bit goes out one cycle before the clock is released
            if (inh_tmr_r == INH_PRE) begin
              data_oe_r <= 1'b1;
            end
            if (inh_tmr_r == INH_LAST) begin
              state_r  <= ST_REQ;
              clk_oe_r <= 1'b0;
            end
          end

          // REQ and SHIFT differ only in name: the first edge leaves REQ
          ST_REQ, ST_SHIFT: begin
            if (clk_fall_s) begin
              edge_cnt_r <= edge_cnt_r + 4'd1;
              if ((edge_cnt_r + 4'd1) == EDGE_STOP) begin
                data_oe_r <= 1'b0;
                state_r   <= ST_ACK;
              end else begin
                data_oe_r <= ~frame_r[0];
                frame_r   <= {1'b0, frame_r[8:1]};
                state_r   <= ST_SHIFT;
              end
            end
          end

          ST_ACK: begin
            if (clk_fall_s) begin
              edge_cnt_r <= EDGE_ACK;
              nack_r     <= data_filt_s;
              state_r    <= ST_WAIT_IDLE;
            end
          end

          // Further device edges are ignored; only an idle bus ends the frame
          ST_WAIT_IDLE: begin
            if (clk_filt_s && data_filt_s) begin
              state_r   <= ST_IDLE;
              busy_r    <= 1'b0;
              done_r    <= ~nack_r;
              ack_err_r <= nack_r;
            end
          end

          default: begin
            state_r   <= ST_IDLE;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign clkps2_oe  = clk_oe_r;
  assign dataps2_oe = data_oe_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign ack_err    = ack_err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx at CLK_KHZ=12000. A simple PS/2 device model
// generates the clock (25-cycle half period), records what the host puts on
// the data line after edges 1-9 and answers edge 11 with ACK or no-ACK.
// Lines are modelled as open-drain wired-AND of host and device.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int H   = 25;
  localparam int INH = 1200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       clkps2_in;
  logic       dataps2_in;
  logic       clkps2_oe;
  logic       dataps2_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       tmo_err;
  logic       dev_clk;
  logic       dev_data;

  int   n_cmp    = 0;
  int   n_err    = 0;
  int   n_done   = 0;
  int   n_ackerr = 0;
  int   n_tmo    = 0;
  logic prev_busy = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    int         extra;
    logic [8:0] exp_oe;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  assign clkps2_in  = ~clkps2_oe  & dev_clk;
  assign dataps2_in = ~dataps2_oe & dev_data;

  ps2_host_tx #(
    .CLK_KHZ  (12000),
    .FILT_LEN (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .clkps2_in  (clkps2_in),
    .dataps2_in (dataps2_in),
    .clkps2_oe  (clkps2_oe),
    .dataps2_oe (dataps2_oe),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .tmo_err    (tmo_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Result pulse monitor
  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (ack_err === 1'b1) n_ackerr++;
    if (tmo_err === 1'b1) n_tmo++;
    if (done === 1'b1 && ack_err === 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_and_ack_err_together: both high at t=%0t, expected at most one", $time);
    end
    if (done === 1'b1 || ack_err === 1'b1 || tmo_err === 1'b1)
      check("busy_falls_with_result", {prev_busy, busy}, 2'b10);
    prev_busy = busy;
  end

  // abort_kind: 1 = rst after edge abort_edge, 2 = device stops after abort_edge
  task automatic run_frame(input logic [7:0] d, input logic ack, input int extra,
                           input int dup_at, input int abort_edge, input int abort_kind,
                           input logic [8:0] exp_oe);
    int d0, a0, t0, inh_cycles, inh_data, k;
    logic [8:0] got_oe;
    d0 = n_done; a0 = n_ackerr; t0 = n_tmo;
    inh_cycles = 0; inh_data = 0; got_oe = 9'h000;
    @(negedge clk); tx_data = d; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0; tx_data = ~d;
    check("busy_after_accept", busy, 1);
    while (clkps2_oe === 1'b1 && inh_cycles < 3000) begin
      inh_cycles++;
      if (dataps2_oe === 1'b1) inh_data++;
      if (dup_at > 0 && inh_cycles == dup_at) begin
        tx_data = 8'h00; tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
    check("inhibit_cycles", inh_cycles, INH);
    check("data_rise_in_last_inhibit", inh_data, 1);
    check("start_bit", {clkps2_oe, dataps2_oe}, 2'b01);
    for (int e = 1; e <= 11 + extra; e++) begin
      if (e == 11) dev_data = ~ack;
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (e <= 9) got_oe[e-1] = dataps2_oe;
      if (e == 10) check("stop_bit_release", dataps2_oe, 0);
      if (e == abort_edge) begin
        if (abort_kind == 1) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check("rst_releases_lines", {clkps2_oe, dataps2_oe, busy}, 3'b000);
          dev_clk = 1'b1; dev_data = 1'b1;
          repeat (200) @(negedge clk);
          check("rst_no_pulses", (n_done - d0) + (n_ackerr - a0) + (n_tmo - t0), 0);
        end else begin
          dev_clk = 1'b1; k = 0;
          while (tmo_err !== 1'b1 && k < 26000) begin
            @(negedge clk); k++;
          end
          check("tmo_latency_window", (H + k >= 24000 && H + k <= 24040), 1);
          check("tmo_lines_busy", {clkps2_oe, dataps2_oe, busy}, 3'b000);
          repeat (5) @(negedge clk);
          check("tmo_pulse_count", n_tmo - t0, 1);
          check("tmo_no_done", (n_done - d0) + (n_ackerr - a0), 0);
        end
        return;
      end
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    k = 0;
    while (busy === 1'b1 && k < 500) begin
      @(negedge clk); k++;
    end
    check("result_within_bound", k < 500, 1);
    repeat (5) @(negedge clk);
    check("oe_pattern", got_oe, exp_oe);
    check("done_count", n_done - d0, ack ? 1 : 0);
    check("ack_err_count", n_ackerr - a0, ack ? 0 : 1);
    check("no_tmo", n_tmo - t0, 0);
    check("idle_after", {clkps2_oe, dataps2_oe, busy}, 3'b000);
  endtask

  initial begin
    int act;
    // exp_oe bit i = dataps2_oe after edge i+1 (bits 0-7 data, bit 8 parity)
    tbl[0] = '{data: 8'hF4, ack: 1'b1, extra: 0, exp_oe: 9'h10B};
    tbl[1] = '{data: 8'hFF, ack: 1'b1, extra: 0, exp_oe: 9'h000};
    tbl[2] = '{data: 8'h00, ack: 1'b1, extra: 2, exp_oe: 9'h0FF};
    tbl[3] = '{data: 8'hA5, ack: 1'b1, extra: 0, exp_oe: 9'h05A};
    tbl[4] = '{data: 8'h55, ack: 1'b0, extra: 0, exp_oe: 9'h0AA};

    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_outputs", {clkps2_oe, dataps2_oe, busy, done, ack_err, tmo_err}, 6'b000000);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].data, tbl[i].ack, tbl[i].extra, 0, 0, 0, tbl[i].exp_oe);
      repeat (20) @(negedge clk);
    end

    // Second tx_start while busy must not start another frame
    run_frame(8'hF4, 1'b1, 0, 50, 0, 0, 9'h10B);
    act = 0;
    repeat (1500) begin
      @(negedge clk);
      if (clkps2_oe === 1'b1 || busy === 1'b1) act++;
    end
    check("no_second_frame", act, 0);

    // Reset mid-frame, then a clean frame
    run_frame(8'hA5, 1'b1, 0, 0, 6, 1, 9'h05A);
    run_frame(8'h3C, 1'b1, 0, 0, 0, 0, 9'h0C3);
    repeat (20) @(negedge clk);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    run_frame(8'hF4, 1'b1, 0, 0, 4, 2, 9'h10B);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
